// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtract-based GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// Two-register subtract/compare datapath. The controller picks which side
// shrinks each cycle; this block only loads, subtracts and compares.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_val,
  output logic [WIDTH-1:0] b_val,
  output logic             a_eq_b,
  output logic             a_gt_b
);

  logic [WIDTH-1:0] a_q, b_q;

  // Operand registers: load on start, otherwise shrink the larger side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else begin
      if (sub_a) a_q <= a_q - b_q;
      if (sub_b) b_q <= b_q - a_q;
    end
  end

  assign a_val  = a_q;
  assign b_val  = b_q;
  assign a_eq_b = (a_q == b_q);
  assign a_gt_b = (a_q > b_q);

endmodule

// File: rtl/gcd_controller.sv
// GCD controller: start/result handshakes, FSM sequencing, iteration budget
// and registered result outputs around gcd_datapath.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int WIDTH    = GCD_WIDTH,
  parameter int MAX_ITER = 2**WIDTH - 1,
  localparam int CNT_W   = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  gcd_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_val, b_val;
  logic             a_eq_b, a_gt_b;
  logic             go, in_calc, budget_hit, step;
  logic             load, sub_a, sub_b;

  // start_ready is registered and only high in IDLE, so it doubles as the state qualifier.
  assign go         = start_valid & start_ready;
  assign in_calc    = (state == CALC);
  assign budget_hit = (cnt == MAX_CNT);
  // Equality wins over the budget check, so exactly MAX_ITER steps still converge.
  assign step       = in_calc & ~a_eq_b & ~budget_hit;
  assign load       = go;
  assign sub_a      = step & a_gt_b;
  assign sub_b      = step & ~a_gt_b;
  assign iter_cnt   = cnt;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .sub_a  (sub_a),
    .sub_b  (sub_b),
    .a_in   (a_in),
    .b_in   (b_in),
    .a_val  (a_val),
    .b_val  (b_val),
    .a_eq_b (a_eq_b),
    .a_gt_b (a_gt_b)
  );

  // Sequencing FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      res         <= '0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            cnt         <= '0;
            start_ready <= 1'b0;
            if (a_in == '0 && b_in == '0) begin
              // Degenerate request: no defined GCD.
              res       <= '0;
              err       <= 1'b1;
              res_valid <= 1'b1;
              state     <= DONE;
            end else if (a_in == '0 || b_in == '0) begin
              // gcd(x,0) = x; OR picks the nonzero operand.
              res       <= a_in | b_in;
              err       <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (a_eq_b) begin
            res       <= a_val;
            err       <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (budget_hit) begin
            res       <= '0;
            err       <= 1'b1;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: directed vectors, random operands against a
// Euclid-quotient reference, backpressure/start gating and mid-op reset.
module tb_gcd_controller;

  localparam int W     = 8;
  localparam int MAXI0 = 2**W - 1;
  localparam int MAXI1 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid [2];
  logic       res_ready   [2];
  logic [W-1:0] a_in [2];
  logic [W-1:0] b_in [2];
  logic       start_ready [2];
  logic       res_valid   [2];
  logic       err         [2];
  logic [W-1:0] res [2];
  logic [7:0] iter0;
  logic [2:0] iter1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gcd_controller #(.WIDTH(W)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid[0]), .start_ready(start_ready[0]),
    .a_in(a_in[0]), .b_in(b_in[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res(res[0]), .err(err[0]), .iter_cnt(iter0)
  );

  gcd_controller #(.WIDTH(W), .MAX_ITER(MAXI1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid[1]), .start_ready(start_ready[1]),
    .a_in(a_in[1]), .b_in(b_in[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res(res[1]), .err(err[1]), .iter_cnt(iter1)
  );

  typedef struct {
    int a, b, r, e, n, lat;
  } vec_t;

  function automatic int get_iter(input int sel);
    return (sel == 0) ? int'(iter0) : int'(iter1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: subtraction count is the sum of Euclid quotients, with the
  // final exact division contributing one fewer step.
  task automatic model(input int a, input int b, input int maxi,
                       output int r, output int e, output int n, output int lat);
    int x, y, t, q, g, c;
    if (a == 0 && b == 0) begin
      r = 0; e = 1; n = 0; lat = 1;
    end else if (a == 0 || b == 0) begin
      r = a + b; e = 0; n = 0; lat = 1;
    end else begin
      x = a; y = b; c = 0; g = 0;
      forever begin
        if (x < y) begin t = x; x = y; y = t; end
        q = x / y;
        if (x % y == 0) begin
          c += q - 1; g = y; break;
        end
        c += q; x = x % y;
      end
      if (c > maxi) begin r = 0; e = 1; n = maxi; lat = 2 + maxi; end
      else          begin r = g; e = 0; n = c;    lat = 2 + c;    end
    end
  endtask

  // Called at a negedge with res_ready high; returns at a negedge after the
  // result handshake.
  task automatic run_op(input int sel, input int a, input int b, input int er,
                        input int ee, input int en, input int elat, input string nm);
    int  lat;
    bit  got;
    chk({nm, " start_ready"}, int'(start_ready[sel]), 1);
    start_valid[sel] = 1'b1;
    a_in[sel] = W'(a);
    b_in[sel] = W'(b);
    @(posedge clk);
    #1 start_valid[sel] = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 600) begin
      @(negedge clk);
      lat++;
      if (res_valid[sel]) got = 1;
    end
    chk({nm, " res_valid seen"}, int'(got), 1);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " res"}, int'(res[sel]), er);
    chk({nm, " err"}, int'(err[sel]), ee);
    chk({nm, " iter_cnt"}, get_iter(sel), en);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " idle after handshake"}, int'({start_ready[sel], res_valid[sel]}), 2);
  endtask

  initial begin
    vec_t vecs[$];
    int r, e, n, lat, a, b;
    int hold_res, hold_err, hold_it;
    bit got;

    for (int i = 0; i < 2; i++) begin
      start_valid[i] = 1'b0; res_ready[i] = 1'b1; a_in[i] = '0; b_in[i] = '0;
    end

    // Reset state
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset start_ready", int'(start_ready[i]), 1);
      chk("reset res_valid", int'(res_valid[i]), 0);
      chk("reset res", int'(res[i]), 0);
      chk("reset err", int'(err[i]), 0);
      chk("reset iter_cnt", get_iter(i), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table (default budget)
    vecs.push_back('{12, 18, 6, 0, 2, 4});
    vecs.push_back('{7, 7, 7, 0, 0, 2});
    vecs.push_back('{0, 9, 9, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 1});
    vecs.push_back('{9, 0, 9, 0, 0, 1});
    vecs.push_back('{255, 1, 1, 0, 254, 256});
    vecs.push_back('{1, 255, 1, 0, 254, 256});
    foreach (vecs[i])
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, vecs[i].n, vecs[i].lat,
             $sformatf("vec%0d(%0d,%0d)", i, vecs[i].a, vecs[i].b));

    // Timeout with MAX_ITER=4, plus an exact-budget convergence: (5,1) needs 4
    run_op(1, 100, 3, 0, 1, 4, 6, "timeout(100,3)");
    run_op(1, 5, 1, 1, 0, 4, 6, "budget_exact(5,1)");
    run_op(1, 6, 1, 0, 1, 4, 6, "budget_over(6,1)");

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (i % 5 == 0) a = 0;
      model(a, b, MAXI0, r, e, n, lat);
      run_op(0, a, b, r, e, n, lat, $sformatf("rnd0(%0d,%0d)", a, b));
    end
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      model(a, b, MAXI1, r, e, n, lat);
      run_op(1, a, b, r, e, n, lat, $sformatf("rnd1(%0d,%0d)", a, b));
    end

    // Backpressure and start gating
    res_ready[0] = 1'b0;
    start_valid[0] = 1'b1; a_in[0] = 8'd12; b_in[0] = 8'd18;
    @(posedge clk);
    #1 start_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp calc start_ready", int'(start_ready[0]), 0);
    start_valid[0] = 1'b1; a_in[0] = 8'd1; b_in[0] = 8'd1;
    @(negedge clk);
    start_valid[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (res_valid[0]) got = 1;
    end
    chk("bp res_valid seen", int'(got), 1);
    hold_res = int'(res[0]); hold_err = int'(err[0]); hold_it = int'(iter0);
    chk("bp res", hold_res, 6);
    chk("bp iter", hold_it, 2);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin start_valid[0] = 1'b1; a_in[0] = 8'd5; b_in[0] = 8'd0; end
      if (c == 4) start_valid[0] = 1'b0;
      @(negedge clk);
      if ({res_valid[0], start_ready[0]} != 2'b10 || int'(res[0]) != hold_res ||
          int'(err[0]) != hold_err || int'(iter0) != hold_it)
        chk($sformatf("bp hold cycle %0d", c),
            {int'(res_valid[0]), int'(start_ready[0]), int'(res[0])}, 0);
      else checks++;
    end
    res_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp release start_ready", int'(start_ready[0]), 1);
    chk("bp release res_valid", int'(res_valid[0]), 0);
    run_op(0, 7, 7, 7, 0, 0, 2, "bp next(7,7)");

    // Reset mid-operation
    start_valid[0] = 1'b1; a_in[0] = 8'd200; b_in[0] = 8'd3;
    @(posedge clk);
    #1 start_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid busy", int'(start_ready[0]), 0);
    chk("mid iter advancing", int'(iter0 != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst start_ready", int'(start_ready[0]), 1);
    chk("mid rst res_valid", int'(res_valid[0]), 0);
    chk("mid rst res", int'(res[0]), 0);
    chk("mid rst err", int'(err[0]), 0);
    chk("mid rst iter", int'(iter0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_valid[0]) got = 1;
    end
    chk("mid no stale result", int'(got), 0);
    run_op(0, 8, 12, 4, 0, 2, 4, "after rst(8,12)");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Iterative subtract-based GCD engine: an FSM sequencing a two-register subtract/compare datapath behind a valid/ready request and response handshake. It accepts two unsigned operands and repeatedly subtracts the smaller from the larger until they are equal. It reports the result, the iteration count and an error flag. It is the control and sequencing layer around the team's constant and equality comparators in the GCD design.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2).
- `MAX_ITER`, 2**WIDTH-1, subtraction budget before timeout (≥1).
- `CNT_W`, $clog2(MAX_ITER+1), iteration counter width (derived localparam).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  operand request valid.
- `start_ready`  out  1  controller can accept operands.
- `a_in`  in  WIDTH  operand A, sampled on start handshake.
- `b_in`  in  WIDTH  operand B, sampled on start handshake.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts result.
- `res`  out  WIDTH  GCD result.
- `err`  out  1  invalid input (both zero) or iteration timeout.
- `iter_cnt`  out  CNT_W  number of subtractions performed.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE.** `start_ready`=1. On `start_valid` & `start_ready`:
  - Latch A←`a_in`, B←`b_in`, cnt←0.
  - A=0 and B=0: go to DONE with `res`=0, `err`=1.
  - Exactly one operand is zero: go to DONE with `res`=the nonzero operand, `err`=0.
  - Otherwise: go to CALC.
- **CALC**, one decision per cycle, in priority order:
  - A==B: go to DONE with `res`=A, `err`=0.
  - cnt==MAX_ITER: go to DONE with `res`=0, `err`=1.
  - A>B: A←A−B, cnt←cnt+1.
  - Otherwise: B←B−A, cnt←cnt+1.
- **Arithmetic.** Unsigned, WIDTH bits. The larger minus the smaller never underflows. cnt never exceeds MAX_ITER, so there is no wrap.
- **DONE.** `res_valid`=1. `res`, `err` and `iter_cnt` are held stable until `res_valid` & `res_ready`, then the FSM returns to IDLE.
- `start_ready`=0 in CALC and DONE. `start_valid` in those states is ignored and not queued.
- `iter_cnt` mirrors cnt at all times and is frozen in DONE.

## Timing
- Reset values: state=IDLE, `start_ready`=1, `res_valid`=0, `res`=0, `err`=0, `iter_cnt`=0. Internal A, B and cnt are also 0.
- Timing is counted from the start handshake edge (cycle 0):
  - Zero-operand cases: `res_valid` is high at cycle 1.
  - Nonzero operands needing N subtractions: `res_valid` at cycle 2+N.
  - Timeout: `res_valid` at cycle 2+MAX_ITER.
- Result handshake and back-to-back operation:
  - The result handshake at cycle k returns the FSM to IDLE, and `start_ready` is 1 at cycle k+1.
  - The next start can be accepted at cycle k+1.
  - There is no same-cycle result-to-start bypass.
- Backpressure: `res_ready` low holds DONE indefinitely with outputs unchanged.
- Reset mid-operation: asserting `rst_n` low in any state immediately forces reset values. Any in-flight computation is discarded and no result is emitted.

## Structure
- Shared package `gcd_pkg`:
  - State enum `gcd_state_t` (IDLE, CALC, DONE).
  - Default WIDTH constant.
- Sub-module `gcd_datapath`, instantiated once:
  - Contents: the A/B registers, the load mux, the subtractors, and the compare outputs `a_eq_b` and `a_gt_b`.
  - Control inputs: `load`, `sub_a`, `sub_b`.
- `gcd_controller` holds the FSM, the iteration counter, the timeout compare and the output registers.

## Test plan
- **Basic.** WIDTH=8, start (12,18), `res_ready`=1.
  - Expect `res_valid` at cycle 4, `res`=6, `iter_cnt`=2, `err`=0.
  - Follow with (7,7): `res`=7, `iter_cnt`=0, `res_valid` at cycle 2.
- **Zero operands.**
  - (0,9): `res`=9, `err`=0, `res_valid` at cycle 1.
  - (0,0): `res`=0, `err`=1.
- **Worst case.** WIDTH=8, (255,1): `res`=1, `iter_cnt`=254, `err`=0, `res_valid` at cycle 256.
- **Timeout.** MAX_ITER=4, (100,3): `err`=1, `res`=0, `iter_cnt`=4, `res_valid` at cycle 6.
- **Backpressure and start gating.**
  - Hold `res_ready`=0 for 10 cycles while in DONE: outputs stable, `start_ready`=0.
  - A `start_valid` pulse during CALC/DONE is ignored.
  - After the release cycle k, a new start is accepted at k+1.
- **Reset mid-operation.** Assert `rst_n` low during CALC of (200,3). All outputs return to reset values at once, and no `res_valid` is seen. After reset release, (8,12) yields `res`=4.
